// File: rtl/serial_compare_nbit.sv
// Bit-serial magnitude comparator: walks both operands MSB-first, one bit per enabled
// clock, and stops at the first differing bit. Results stay held until the next start.
module serial_compare_nbit #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             G,
    output logic             busy,
    output logic             done,
    output logic             E,
    output logic             M,
    output logic             L
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [WIDTH-1:0]   a_sr_r;
    logic [WIDTH-1:0]   b_sr_r;
    logic [IDX_W-1:0]   idx_r;
    logic               e_r;
    logic               m_r;
    logic               l_r;
    logic               busy_r;
    logic               done_r;

    logic               accept_s;
    logic               differ_s;
    logic               invert_s;
    logic               last_s;
    logic               bit_a_s;
    logic               bit_b_s;

    // The operands shift left, so the bit under examination is always the top bit.
    always_comb begin
        bit_a_s  = a_sr_r[WIDTH-1];
        bit_b_s  = b_sr_r[WIDTH-1];
        differ_s = bit_a_s ^ bit_b_s;
        last_s   = (idx_r == {IDX_W{1'b0}});
        invert_s = (SIGNED != 0) && (idx_r == IDX_W'(WIDTH - 1));
        accept_s = start && G && ((state_r == IDLE) || (state_r == DONE));
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = COMPARE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            COMPARE: begin
                if (G && (differ_s || last_s)) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = COMPARE;
                end
            end
            DONE: begin
                if (accept_s) begin
                    state_next_s = COMPARE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // busy/done are registered from the next state so they line up with state_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == COMPARE);
            done_r <= (state_next_s == DONE);
        end
    end

    // Operand shift registers, bit index and held result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_r <= {WIDTH{1'b0}};
            b_sr_r <= {WIDTH{1'b0}};
            idx_r  <= {IDX_W{1'b0}};
            e_r    <= 1'b0;
            m_r    <= 1'b0;
            l_r    <= 1'b0;
        end else if (accept_s) begin
            a_sr_r <= A;
            b_sr_r <= B;
            idx_r  <= IDX_W'(WIDTH - 1);
            e_r    <= 1'b0;
            m_r    <= 1'b0;
            l_r    <= 1'b0;
        end else if ((state_r == COMPARE) && G) begin
            if (differ_s) begin
                // A set sign bit means the smaller value in two's complement.
                m_r <= invert_s ? bit_b_s : bit_a_s;
                l_r <= invert_s ? bit_a_s : bit_b_s;
            end else if (last_s) begin
                e_r <= 1'b1;
            end else begin
                a_sr_r <= {a_sr_r[WIDTH-2:0], 1'b0};
                b_sr_r <= {b_sr_r[WIDTH-2:0], 1'b0};
                idx_r  <= idx_r - IDX_W'(1);
            end
        end else begin
            a_sr_r <= a_sr_r;
            b_sr_r <= b_sr_r;
            idx_r  <= idx_r;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign E    = e_r;
    assign M    = m_r;
    assign L    = l_r;

endmodule

// File: tb/tb_serial_compare_nbit.sv
// Directed bench for serial_compare_nbit: an unsigned and a signed instance share stimulus;
// expected latencies and flags are hand-computed for WIDTH=8.
module tb_serial_compare_nbit;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             g;
    logic             u_busy, u_done, u_e, u_m, u_l;
    logic             s_busy, s_done, s_e, s_m, s_l;

    int tests = 0;
    int fails = 0;

    serial_compare_nbit #(.WIDTH(WIDTH), .SIGNED(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .G(g),
        .busy(u_busy), .done(u_done), .E(u_e), .M(u_m), .L(u_l)
    );

    serial_compare_nbit #(.WIDTH(WIDTH), .SIGNED(1)) s_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .G(g),
        .busy(s_busy), .done(s_done), .E(s_e), .M(s_m), .L(s_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launches one compare and returns the cycles from the accept edge to done,
    // plus the number of sampled cycles with busy high.
    task automatic run(input logic [7:0] av, input logic [7:0] bv, input bit b2b,
                       input int stall_at, input int stall_len, input int ign_at,
                       output int cyc, output int busy_cnt);
        if (!b2b) @(negedge clk);
        a = av; b = bv; start = 1'b1; g = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = ~av; b = ~bv;
        @(negedge clk);
        cyc = 0;
        busy_cnt = u_busy ? 1 : 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            g = (cyc >= stall_at && cyc < stall_at + stall_len) ? 1'b0 : 1'b1;
            if (ign_at != 0 && cyc == ign_at) begin
                start = 1'b1; a = 8'hFF; b = 8'h00;
            end else begin
                start = 1'b0;
            end
            if (stall_len > 0 && cyc == stall_at + stall_len)
                check("idx_frozen", u_dut.idx_r, WIDTH - 1 - stall_at);
            if (u_busy) busy_cnt++;
            if (u_done) break;
        end
    endtask

    initial begin
        int cyc, bcnt;
        logic done_seen;
        rst_n = 1'b0; start = 1'b0; g = 1'b0; a = 8'h00; b = 8'h00;
        #12;
        check("rst_u_outs", {u_busy, u_done, u_e, u_m, u_l}, 5'b00000);
        check("rst_s_outs", {s_busy, s_done, s_e, s_m, s_l}, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Equal operands: all 8 bits examined.
        run(8'h5A, 8'h5A, 1'b0, 0, 0, 0, cyc, bcnt);
        check("eq_latency", cyc, 8);
        check("eq_busy_cycles", bcnt, 8);
        check("eq_u_eml", {u_e, u_m, u_l}, 3'b100);
        check("eq_s_eml", {s_e, s_m, s_l}, 3'b100);
        @(negedge clk);
        check("eq_done_one_cycle", u_done, 1'b0);
        check("eq_held_idle", {u_e, u_m, u_l}, 3'b100);

        // MSB differs: early termination, sign sense inverted for SIGNED=1.
        run(8'h80, 8'h7F, 1'b0, 0, 0, 0, cyc, bcnt);
        check("msb_latency", cyc, 1);
        check("msb_u_eml", {u_e, u_m, u_l}, 3'b010);
        check("msb_s_eml", {s_e, s_m, s_l}, 3'b001);

        // LSB differs with a 3-cycle stall in the middle.
        run(8'h12, 8'h13, 1'b0, 4, 3, 0, cyc, bcnt);
        check("stall_latency", cyc, 11);
        check("stall_busy_cycles", bcnt, 11);
        check("stall_u_eml", {u_e, u_m, u_l}, 3'b001);

        // Start while busy is ignored; start in DONE is taken back-to-back.
        run(8'h12, 8'h13, 1'b0, 0, 0, 3, cyc, bcnt);
        check("ign_latency", cyc, 8);
        check("ign_u_eml", {u_e, u_m, u_l}, 3'b001);
        check("ign_s_eml", {s_e, s_m, s_l}, 3'b001);
        run(8'h80, 8'h7F, 1'b1, 0, 0, 0, cyc, bcnt);
        check("b2b_latency", cyc, 1);
        check("b2b_u_eml", {u_e, u_m, u_l}, 3'b010);
        check("b2b_s_eml", {s_e, s_m, s_l}, 3'b001);

        // Reset in the middle of a compare.
        @(negedge clk);
        a = 8'h12; b = 8'h13; start = 1'b1; g = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_busy", u_busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_outs", {u_busy, u_done, u_e, u_m, u_l}, 5'b00000);
        check("async_rst_idx", u_dut.idx_r, 0);
        check("async_rst_opa", u_dut.a_sr_r, 0);
        done_seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            done_seen = done_seen | u_done | s_done;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            done_seen = done_seen | u_done | s_done;
        end
        check("rst_no_done", done_seen, 1'b0);
        check("rst_idle", {u_busy, s_busy}, 2'b00);

        // Difference at bit 6 after reset: two bits examined.
        run(8'h40, 8'h20, 1'b0, 0, 0, 0, cyc, bcnt);
        check("mid_latency", cyc, 2);
        check("mid_u_eml", {u_e, u_m, u_l}, 3'b010);
        check("mid_s_eml", {s_e, s_m, s_l}, 3'b010);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
